// File: rtl/sw_led_pkg.sv
// Shared constants for the sw_led_avs register block: Avalon data width,
// word-address type and the register map.
package sw_led_pkg;

  localparam int AVS_DW = 32;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_DATA = 2'd0;
  localparam reg_addr_t ADDR_LED  = 2'd1;
  localparam reg_addr_t ADDR_MASK = 2'd2;
  localparam reg_addr_t ADDR_EDGE = 2'd3;

endpackage

// File: rtl/sw_debouncer.sv
// Switch input conditioning: 2-flop synchronizer followed by an optional
// whole-vector debouncer. Define SW_DEBOUNCE_EN to compile the debouncer in;
// otherwise the synchronized vector is registered straight into stable.
module sw_debouncer #(
  parameter int W      = 10,
  parameter int CYCLES = 500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw_in,
  output logic [W-1:0] stable
);

  // A window shorter than two cycles cannot separate a glitch from a change.
  if (CYCLES < 2) begin : g_bad_cycles
    $error("sw_debouncer: CYCLES must be at least 2");
  end

  logic [W-1:0] sync0;
  logic [W-1:0] sync;

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0 <= '0;
      sync  <= '0;
    end else begin
      sync0 <= sw_in;
      sync  <= sync0;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CNT_W = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic [W-1:0]     cand;
  logic [CNT_W-1:0] cnt;

  // Any change restarts the shared window; stable follows cand once the
  // window has run out, and the counter then parks at its last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (sync != cand) begin
      cand <= sync;
      cnt  <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= cand;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  // Without debouncing the synchronized vector is taken every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
    end else begin
      stable <= sync;
    end
  end
`endif

endmodule

// File: rtl/sw_led_avs.sv
// Avalon-MM switch/LED register block: DATA (RO), LED (RW), MASK (RW) and
// EDGE (W1C rising-edge capture) with a level irq. Build option
// SW_DEBOUNCE_EN enables the switch debouncer inside sw_debouncer.
module sw_led_avs
  import sw_led_pkg::*;
#(
  parameter int SW_W            = 10,
  parameter int LED_W           = 10,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out
);

  logic [SW_W-1:0]   stable;
  logic [SW_W-1:0]   stable_d;
  logic [SW_W-1:0]   mask_reg;
  logic [SW_W-1:0]   edge_reg;
  logic [SW_W-1:0]   edge_set;
  logic [SW_W-1:0]   edge_clr;
  logic [AVS_DW-1:0] rd_mux;
  logic              unused_wdata;

  // Upper write-data bits are deliberately discarded.
  assign unused_wdata = ^avs_writedata;

  sw_debouncer #(
    .W      (SW_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .sw_in  (sw_in),
    .stable (stable)
  );

  // Rising edges of stable and W1C clear requests for this cycle.
  always_comb begin
    edge_set = stable & ~stable_d;
    edge_clr = '0;
    if (avs_write && (avs_address == ADDR_EDGE)) begin
      edge_clr = avs_writedata[SW_W-1:0];
    end
  end

  // Register file updates; a set beats a same-cycle clear of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out  <= '0;
      mask_reg <= '0;
      edge_reg <= '0;
      stable_d <= '0;
    end else begin
      stable_d <= stable;
      edge_reg <= (edge_reg & ~edge_clr) | edge_set;
      if (avs_write && (avs_address == ADDR_LED)) begin
        led_out <= avs_writedata[LED_W-1:0];
      end
      if (avs_write && (avs_address == ADDR_MASK)) begin
        mask_reg <= avs_writedata[SW_W-1:0];
      end
    end
  end

  // Read mux of the current (pre-write) register values, zero-extended.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA: rd_mux = AVS_DW'(stable);
      ADDR_LED:  rd_mux = AVS_DW'(led_out);
      ADDR_MASK: rd_mux = AVS_DW'(mask_reg);
      ADDR_EDGE: rd_mux = AVS_DW'(edge_reg);
      default:   rd_mux = '0;
    endcase
  end

  // Read data register: fixed latency 1, holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

  assign irq = |(edge_reg & mask_reg);

endmodule

// File: doc/sw_led_avs.md
# sw_led_avs

Avalon-MM responder peripheral for the Nios-II `cpu_system`, the target side of the CPU's data master. It replaces the stock switch and LED PIOs with one custom register block. It drives `ledr` from a CPU-writable register and presents the synchronized, optionally debounced `sw` inputs to the CPU, with rising-edge capture and a maskable interrupt. It is instantiated inside the Platform Designer system, and its conduits are exported to the board top.

## Interface
- `SW_W`, default 10: switch input width.
- `LED_W`, default 10: LED output width.
- `DEBOUNCE_CYCLES`, default 500000: stability window in clk cycles, 10 ms at 50 MHz. Legal range is ≥ 2.

Ports:
- `clk`  in  1: system clock, `clock_50` domain.
- `reset`  in  1: asynchronous, active-high reset.
- `avs_address`  in  2: word address.
- `avs_read`  in  1: read strobe.
- `avs_write`  in  1: write strobe.
- `avs_writedata`  in  32: write data.
- `avs_readdata`  out  32: read data, fixed read latency 1.
- `irq`  out  1: level interrupt to the CPU.
- `sw_in`  in  `SW_W`: raw asynchronous switches.
- `led_out`  out  `LED_W`: LED drive.

## Operation
Register map (word addresses):
- 0 DATA (RO): stable switch vector in `[SW_W-1:0]`. Writes are ignored.
- 1 LED (RW): `led_out = LED[LED_W-1:0]`.
- 2 MASK (RW): per-bit interrupt enable, `[SW_W-1:0]`.
- 3 EDGE (R/W1C): rising-edge capture bits. Writing 1 clears a bit; writing 0 leaves it unchanged.

Register and output rules:
- Unused upper bits read as 0. Writes to unused upper bits are discarded.
- Reset values: `led_out`=0, `avs_readdata`=0, `irq`=0, MASK=0, EDGE=0, stable=0, synchronizer=0, debounce counter=0.
- Input path: `sw_in` passes through a 2-flop synchronizer (`sync`), then the debouncer, producing `stable`.
- Edge capture: `EDGE[i]` is set on the cycle after `stable[i]` goes 0→1. Falling edges are not captured.
- If a set and a W1C clear of the same bit occur in the same cycle, the set wins.
- `irq = |(EDGE & MASK)`. It is combinational from registers, so there is no added latency.
- Simultaneous `avs_read` and `avs_write` is illegal for the master. If it occurs, the write takes effect and the read returns the pre-write value.
- There is no waitrequest. Every access completes in one cycle.

Debouncer behaviour (debounce compiled in):
- `cand` register plus a counter of width `$clog2(DEBOUNCE_CYCLES)`.
- If `sync != cand`: `cand <= sync` and `cnt <= 0`.
- Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`. The counter holds (saturates) at this value.
- Otherwise: `cnt <= cnt+1`.
- One counter covers the whole vector. Any bit change restarts the window for all bits.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `stable`.
- Asserting `reset` mid-window clears `cand`, `cnt` and `stable` immediately.

## Timing
- Write: register updates at the clock edge sampling `avs_write`. `led_out` changes at that same edge.
- Read: `avs_readdata` is valid on the cycle after `avs_read` is sampled. It holds its last value otherwise.
- A read issued in the same cycle as a write to the same address returns the old value.
- Debounce off: a `sw_in` change sampled at edge k appears in `stable` at edge k+2. The EDGE bit sets at k+3, and `irq` rises in that same cycle.
- Debounce on: `stable` updates `DEBOUNCE_CYCLES` cycles after `cand` captures the new value. `cand` captures at edge k+2. EDGE sets one cycle after `stable` updates.

## Configuration
- `SW_DEBOUNCE_EN` defined: the debouncer described above is compiled in.
- Undefined: `stable <= sync` every cycle. There is no counter or `cand` logic, and `DEBOUNCE_CYCLES` is unused.

## Structure
- Package `sw_led_pkg` holds:
  - the address constants `ADDR_DATA`=0, `ADDR_LED`=1, `ADDR_MASK`=2, `ADDR_EDGE`=3;
  - the typedef `reg_addr_t` (logic [1:0]);
  - the data width constant `AVS_DW`=32.
- One sub-module, `sw_debouncer` (parameters `W` and `CYCLES`), contains the synchronizer and the debounce logic. The `SW_DEBOUNCE_EN` guard lives inside it.
- The top level holds the registers, the Avalon decode and the irq logic.

## Test plan
The bench uses `DEBOUNCE_CYCLES`=4 and `SW_W`=`LED_W`=10.
- Reset check: assert reset mid-operation → all outputs 0. Then read addresses 0 to 3 → 0 each.
- LED write/read: write 0x3A5 to address 1 → `led_out`=0x3A5 at that edge. A read of address 1 returns 0x000003A5 one cycle later. Write 0xFFFFFFFF → read returns 0x3FF.
- Switch path, debounce off: set `sw_in`=0x001 → DATA reads 0x001 from edge k+2. EDGE=0x001 at k+3. With MASK=0x001, `irq`=1 at k+3. Write 0x001 to address 3 → `irq`=0 on the next cycle.
- Debounce glitch, on: pulse `sw_in[0]` high for 3 cycles → DATA stays 0 and EDGE stays 0. Hold it high for 6 cycles → DATA=0x001.
- W1C collision: make a rising edge on bit 2 in the same cycle as a write of 0x004 to address 3 → EDGE[2] remains 1.
- Mask: EDGE=0x010 with MASK=0 → `irq`=0. Then write MASK=0x010 → `irq`=1 on the next cycle.
